// File: rtl/word_32_bit_uart_tx.sv
// Serialises a 32-bit word (8 tagged bytes) or a command (2 bytes) as 8N1.
// Ports: clk, reset (sync, active-low), start, cmd_mode, data[31:0] in;
//        tx (serial, idle high), busy, word_done (1-cycle pulse) out.
module word_32_bit_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int GAP_BITS     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cmd_mode,
    input  logic [31:0] data,
    output logic        tx,
    output logic        busy,
    output logic        word_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [2:0]    byte_idx, byte_idx_n;
    logic [GW-1:0] gap_idx, gap_idx_n;
    logic [31:0]   data_q;
    logic          cmd_q;
    logic          load;
    logic          bit_end;
    logic          last_byte;
    logic [7:0]    cur_byte;

    assign bit_end   = (clk_cnt == BIT_LAST);
    assign last_byte = (byte_idx == (cmd_q ? 3'd1 : 3'd7));

    // Even byte slots carry a tag, odd slots carry the latched payload.
    always_comb begin
        cur_byte = data_q[{byte_idx[2:1], 3'b000} +: 8];
        if (!byte_idx[0]) begin
            cur_byte = cmd_q ? 8'h00
                     : {5'd0, {1'b0, byte_idx[2:1]} + 3'd1};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            gap_idx  <= '0;
            data_q   <= '0;
            cmd_q    <= 1'b0;
        end else begin
            state    <= state_n;
            clk_cnt  <= clk_cnt_n;
            bit_idx  <= bit_idx_n;
            byte_idx <= byte_idx_n;
            gap_idx  <= gap_idx_n;
            if (load) begin
                data_q <= data;
                cmd_q  <= cmd_mode;
            end
        end
    end

    always_comb begin
        state_n    = state;
        clk_cnt_n  = bit_end ? '0 : clk_cnt + CW'(1);
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        gap_idx_n  = gap_idx;
        load       = 1'b0;
        tx         = 1'b1;
        busy       = 1'b1;
        word_done  = 1'b0;
        unique case (state)
            IDLE: begin
                busy       = 1'b0;
                clk_cnt_n  = '0;
                bit_idx_n  = '0;
                byte_idx_n = '0;
                gap_idx_n  = '0;
                if (start) begin
                    load    = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                tx = cur_byte[bit_idx];
                if (bit_end) begin
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (last_byte) begin
                        state_n = DONE;
                    end else begin
                        byte_idx_n = byte_idx + 3'd1;
                        gap_idx_n  = '0;
                        state_n    = (GAP_BITS == 0) ? START : GAP;
                    end
                end
            end
            GAP: begin
                if (bit_end) begin
                    gap_idx_n = gap_idx + GW'(1);
                    if (int'(gap_idx) == GAP_BITS - 1) begin
                        gap_idx_n = '0;
                        state_n   = START;
                    end
                end
            end
            DONE: begin
                word_done  = 1'b1;
                clk_cnt_n  = '0;
                bit_idx_n  = '0;
                byte_idx_n = '0;
                gap_idx_n  = '0;
                state_n    = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_word_32_bit_uart_tx.sv
// Scoreboard bench for word_32_bit_uart_tx (CLKS_PER_BIT=4, GAP_BITS=1).
// Stimulus queues expected bytes/done cycles; a monitor decodes tx.
module tb_word_32_bit_uart_tx;

    localparam int CPB = 4;
    localparam int GAP = 1;

    logic        clk;
    logic        reset;
    logic        start;
    logic        cmd_mode;
    logic [31:0] data;
    logic        tx;
    logic        busy;
    logic        word_done;

    int          cyc = 0;
    int          n_total = 0;
    int          n_pass = 0;
    logic [7:0]  exp_q[$];
    int          exp_done[$];

    bit          mact = 0;
    int          mcnt = 0;
    bit          busy_chk = 0;
    logic [7:0]  sh;

    word_32_bit_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .GAP_BITS(GAP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .cmd_mode(cmd_mode),
        .data(data),
        .tx(tx),
        .busy(busy),
        .word_done(word_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h",
                      name, act, exp);
    endtask

    // Monitor: decode serial bytes and word_done pulses.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            mact     = 0;
            busy_chk = 0;
            exp_q.delete();
            exp_done.delete();
        end else begin
            if (busy_chk) begin
                check("busy_fall", busy, 0);
                busy_chk = 0;
            end
            if (word_done === 1'b1) begin
                if (exp_done.size() == 0) begin
                    n_total++;
                    $display("FAIL extra_done: got pulse at %0d expected none",
                             cyc);
                end else begin
                    check("done_cycle", cyc, exp_done.pop_front());
                    check("done_tx", tx, 1);
                    check("done_busy", busy, 1);
                    busy_chk = 1;
                end
            end
            if (!mact) begin
                if (tx === 1'b0) begin
                    mact = 1;
                    mcnt = 0;
                end
            end else begin
                mcnt++;
                if (mcnt == 2) begin
                    check("start_bit", tx, 0);
                end else if (mcnt >= 6 && mcnt <= 34
                             && (mcnt % 4) == 2) begin
                    sh[(mcnt - 6) / 4] = tx;
                end else if (mcnt == 38) begin
                    check("stop_bit", tx, 1);
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL extra_byte: got %0h expected none",
                                 sh);
                    end else begin
                        check("byte", sh, exp_q.pop_front());
                    end
                    mact = 0;
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) check("idle_timeout", busy, 0);
    endtask

    // eb holds nb expected bytes, first byte most significant.
    task automatic send(input logic        c,
                        input logic [31:0] d,
                        input logic [63:0] eb,
                        input int          nb,
                        input int          len);
        int a;
        wait_idle();
        cmd_mode = c;
        data     = d;
        start    = 1'b1;
        a        = cyc + 1;
        for (int i = 0; i < nb; i++)
            exp_q.push_back(eb[8*(nb-1-i) +: 8]);
        exp_done.push_back(a + len);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int a;
        reset    = 1'b0;
        start    = 1'b1;
        cmd_mode = 1'b0;
        data     = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", word_done, 0);
        @(posedge clk);
        #1 start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rst_start_ignored", busy, 0);

        send(0, 32'hDEADBEEF, 64'h01EF02BE03AD04DE, 8, 348);
        wait_idle();

        send(1, 32'h000000A5, 64'h00A5, 2, 84);
        repeat (40) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("gap_tx", tx, 1);
            @(negedge clk);
        end
        check("gap_end_start", tx, 0);
        wait_idle();

        send(0, 32'hCAFEF00D, 64'h010D02F003FE04CA, 8, 348);
        repeat (100) @(negedge clk);
        start = 1'b1;
        data  = 32'h11223344;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        send(0, 32'h12345678, 64'h0178025603340412, 8, 348);
        data = 32'hFFFFFFFF;
        wait_idle();

        send(0, 32'h55AA55AA, 64'h01AA025503AA0455, 8, 348);
        repeat (60) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_done", word_done, 0);
        repeat (400) @(negedge clk);
        send(0, 32'h00000001, 64'h0101020003000400, 8, 348);
        wait_idle();

        cmd_mode = 1'b1;
        data     = 32'h0000003C;
        start    = 1'b1;
        a        = cyc + 1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h3C);
        exp_done.push_back(a + 84);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h3C);
        exp_done.push_back(a + 170);
        repeat (101) @(negedge clk);
        start = 1'b0;
        wait_idle();

        repeat (5) @(negedge clk);
        check("bytes_left", exp_q.size(), 0);
        check("dones_left", exp_done.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
